vie_sram_arbiter: RTL and testbench

Two-to-one arbiter sharing a single SRAM-like memory port between the instruction-fetch requester and the data (load/store) requester. It sits between the fetch and memory stages and the memory-side bridge. It picks one requester per cycle and holds that choice until the address handshake completes. It records each accepted transaction's owner in an in-order FIFO so that every `data_ok` and `rdata` returns to the requester that issued it.

---
 rtl/vie_sram_arbiter.sv | 109 ++++++++++
 tb/tb_vie_sram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vie_sram_arbiter.sv
// Two-to-one arbiter sharing one SRAM-like port between instruction fetch and data access.
// Grant is held until the address handshake; an in-order owner FIFO routes each response home.
module vie_sram_arbiter #(
  parameter int OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        resp_err
);

  localparam int AW = $clog2(OUTSTANDING);

  logic                   lock_v;
  logic                   lock_own;
  logic [OUTSTANDING-1:0] own_q;
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;

  logic empty;
  logic full;
  logic grant_data;
  logic grant_req;
  logic push;
  logic pop;
  logic head;

  // Pointers carry a wrap bit so full and empty are distinguishable with equal indices.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = own_q[rd_ptr[AW-1:0]];

  assign grant_data = lock_v ? lock_own : data_req;
  assign grant_req  = grant_data ? data_req : inst_req;

  assign mem_req   = grant_req & ~full & ~reset;
  assign mem_wr    = grant_data ? data_wr    : inst_wr;
  assign mem_size  = grant_data ? data_size  : inst_size;
  assign mem_wstrb = grant_data ? data_wstrb : inst_wstrb;
  assign mem_addr  = grant_data ? data_addr  : inst_addr;
  assign mem_wdata = grant_data ? data_wdata : inst_wdata;

  assign push = mem_req & mem_addr_ok;
  assign pop  = mem_data_ok & ~empty & ~reset;

  assign inst_addr_ok = push & ~grant_data;
  assign data_addr_ok = push &  grant_data;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop &  head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign busy = ~empty & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_v   <= 1'b0;
      lock_own <= 1'b0;
      own_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      resp_err <= 1'b0;
    end else begin
      if (push) begin
        own_q[wr_ptr[AW-1:0]] <= grant_data;
        wr_ptr                <= wr_ptr + (AW+1)'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
      // Hold the current owner until its address is taken so the command stays stable.
      if (push) begin
        lock_v <= 1'b0;
      end else if (mem_req) begin
        lock_v   <= 1'b1;
        lock_own <= grant_data;
      end
      if (mem_data_ok && empty)
        resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vie_sram_arbiter.sv
// Directed scenario tasks plus randomized traffic checked against a queue-based owner model.
module tb_vie_sram_arbiter;
  localparam int OUT = 4;

  logic        clock, reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        busy, resp_err;

  int tests = 0;
  int fails = 0;

  vie_sram_arbiter #(.OUTSTANDING(OUT)) dut (
    .clock(clock), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy), .resp_err(resp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
  endtask

  task automatic test_reset();
    reset = 1; inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    #1;
    tests++;
    if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 000000",
               {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy});
    end
    tick(); tick();
    tests++;
    if (resp_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", resp_err); end
    idle();
  endtask

  task automatic test_first_grant();
    reset = 0; inst_req = 1; data_req = 1; mem_addr_ok = 1;
    inst_addr = 32'h100; data_addr = 32'h200;
    #1;
    tests++;
    if ({mem_req, data_addr_ok, inst_addr_ok, busy} !== 4'b1100 || mem_addr !== 32'h200) begin
      fails++;
      $display("FAIL first_grant: got req/dok/iok/busy=%b addr=%h want 1100 addr=00000200",
               {mem_req, data_addr_ok, inst_addr_ok, busy}, mem_addr);
    end
    tick(); idle(); #1;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL first_busy: got %b want 1", busy); end
    mem_data_ok = 1; mem_rdata = 32'hcafe0001; #1;
    tests++;
    if ({inst_data_ok, data_data_ok} !== 2'b01 || data_rdata !== 32'hcafe0001) begin
      fails++;
      $display("FAIL first_resp: got i/d=%b rdata=%h want 01 cafe0001",
               {inst_data_ok, data_data_ok}, data_rdata);
    end
    tick(); idle(); #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL first_busy_fall: got %b want 0", busy); end
  endtask

  task automatic test_lock();
    inst_req = 1; inst_addr = 32'hbfc00000; data_addr = 32'h00001000; mem_addr_ok = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) data_req = 1;
      if (c == 4) mem_addr_ok = 1;
      if (c == 5) inst_req = 0;
      #1;
      tests++;
      if (c < 5 && (mem_addr !== 32'hbfc00000 || data_addr_ok !== 1'b0 ||
                    inst_addr_ok !== (c == 4))) begin
        fails++;
        $display("FAIL lock_hold c%0d: got addr=%h iok=%b dok=%b want bfc00000 %b 0",
                 c, mem_addr, inst_addr_ok, data_addr_ok, c == 4);
      end
      if (c == 5 && (mem_addr !== 32'h00001000 || data_addr_ok !== 1'b1)) begin
        fails++;
        $display("FAIL lock_next: got addr=%h dok=%b want 00001000 1", mem_addr, data_addr_ok);
      end
      tick();
    end
    idle(); mem_data_ok = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests++;
      if ({inst_data_ok, data_data_ok} !== (k == 0 ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL lock_drain %0d: got i/d=%b want %b", k, {inst_data_ok, data_data_ok},
                 k == 0 ? 2'b10 : 2'b01);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_order();
    logic [31:0] rd [4];
    rd[0] = 32'h11; rd[1] = 32'h22; rd[2] = 32'h33; rd[3] = 32'h44;
    mem_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      inst_req = (k % 2 == 0); data_req = (k % 2 == 1);
      tick();
    end
    idle(); mem_data_ok = 1;
    for (int k = 0; k < 4; k++) begin
      mem_rdata = rd[k]; #1;
      tests++;
      if ({inst_data_ok, data_data_ok} !== (k % 2 == 0 ? 2'b10 : 2'b01) || busy !== 1'b1 ||
          inst_rdata !== rd[k] || data_rdata !== rd[k]) begin
        fails++;
        $display("FAIL order %0d: got i/d=%b busy=%b rdata=%h/%h want %b 1 %h", k,
                 {inst_data_ok, data_data_ok}, busy, inst_rdata, data_rdata,
                 k % 2 == 0 ? 2'b10 : 2'b01, rd[k]);
      end
      tick();
    end
    idle(); #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL order_busy: got %b want 0", busy); end
  endtask

  task automatic test_full();
    inst_req = 1; mem_addr_ok = 1;
    for (int k = 0; k < OUT; k++) tick();
    #1;
    tests++;
    if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0) begin
      fails++; $display("FAIL full_block: got req=%b iok=%b want 0 0", mem_req, inst_addr_ok);
    end
    mem_data_ok = 1; #1;
    tests++;
    if (mem_req !== 1'b0 || inst_data_ok !== 1'b1) begin
      fails++; $display("FAIL full_pop: got req=%b idok=%b want 0 1", mem_req, inst_data_ok);
    end
    tick(); #1;
    tests++;
    if (mem_req !== 1'b1 || inst_addr_ok !== 1'b1 || inst_data_ok !== 1'b1) begin
      fails++;
      $display("FAIL full_pushpop: got req=%b iok=%b idok=%b want 1 1 1",
               mem_req, inst_addr_ok, inst_data_ok);
    end
    tick(); mem_data_ok = 0; #1;
    tests++;
    if (mem_req !== 1'b1) begin fails++; $display("FAIL full_after_pp: got %b want 1", mem_req); end
    tick(); #1;
    tests++;
    if (mem_req !== 1'b0) begin fails++; $display("FAIL full_again: got %b want 0", mem_req); end
    idle(); mem_data_ok = 1;
    for (int k = 0; k < OUT; k++) tick();
    idle(); #1;
    tests++;
    if (busy !== 1'b0 || resp_err !== 1'b0) begin
      fails++; $display("FAIL full_drain: got busy=%b err=%b want 0 0", busy, resp_err);
    end
  endtask

  task automatic test_spurious();
    mem_data_ok = 1; #1;
    tests++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      fails++; $display("FAIL spur_route: got %b want 00", {inst_data_ok, data_data_ok});
    end
    tick(); idle(); tick(); #1;
    tests++;
    if (resp_err !== 1'b1) begin fails++; $display("FAIL spur_sticky: got %b want 1", resp_err); end
    reset = 1; tick(); reset = 0; #1;
    tests++;
    if (resp_err !== 1'b0) begin fails++; $display("FAIL spur_clear: got %b want 0", resp_err); end
  endtask

  task automatic test_abandon();
    inst_req = 1; mem_addr_ok = 1; tick(); tick(); idle();
    reset = 1; #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL abandon_busy: got %b want 0", busy); end
    tick(); reset = 0; mem_data_ok = 1; #1;
    tests++;
    if ({inst_data_ok, data_data_ok, busy} !== 3'b000) begin
      fails++; $display("FAIL abandon_route: got %b want 000", {inst_data_ok, data_data_ok, busy});
    end
    tick(); idle(); #1;
    tests++;
    if (resp_err !== 1'b1) begin fails++; $display("FAIL abandon_err: got %b want 1", resp_err); end
    reset = 1; tick(); reset = 0;
  endtask

  // Model: owners are a queue; a stalled request pins its owner until accepted.
  task automatic test_random();
    bit q[$];
    bit held_v = 0, held_own = 0, err = 0;
    bit own, req, ereq, pop, eiok, edok, eidok, eddok;
    for (int c = 0; c < 400; c++) begin
      inst_req = ($urandom_range(0, 3) != 0); data_req = ($urandom_range(0, 2) == 0);
      inst_wr = $urandom; data_wr = $urandom;
      inst_size = $urandom; data_size = $urandom;
      inst_wstrb = $urandom; data_wstrb = $urandom;
      inst_addr = $urandom; data_addr = $urandom;
      inst_wdata = $urandom; data_wdata = $urandom;
      mem_addr_ok = $urandom; mem_data_ok = ($urandom_range(0, 2) != 0); mem_rdata = $urandom;
      own  = held_v ? held_own : data_req;
      req  = own ? data_req : inst_req;
      ereq = req && (q.size() < OUT);
      eiok = ereq && mem_addr_ok && !own;
      edok = ereq && mem_addr_ok && own;
      pop  = mem_data_ok && (q.size() > 0);
      eidok = pop && (q[0] == 0);
      eddok = pop && (q[0] == 1);
      #1;
      tests++;
      if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy, resp_err} !==
          {ereq, eiok, edok, eidok, eddok, q.size() > 0, err}) begin
        fails++;
        $display("FAIL rand_ctl c%0d: got %b want %b", c,
                 {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy, resp_err},
                 {ereq, eiok, edok, eidok, eddok, q.size() > 0, err});
      end
      tests++;
      if ({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata, inst_rdata, data_rdata} !==
          (own ? {data_wr, data_size, data_wstrb, data_addr, data_wdata, mem_rdata, mem_rdata}
               : {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata, mem_rdata, mem_rdata}))
      begin
        fails++;
        $display("FAIL rand_cmd c%0d: got addr=%h own_expected=%0d", c, mem_addr, own);
      end
      if (mem_data_ok && q.size() == 0) err = 1;
      if (pop) void'(q.pop_front());
      if (ereq && mem_addr_ok) begin
        q.push_back(own); held_v = 0;
      end else if (ereq) begin
        held_v = 1; held_own = own;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    inst_wr = 0; data_wr = 0; inst_size = 2; data_size = 2; inst_wstrb = 4'hf; data_wstrb = 4'hf;
    inst_addr = 0; data_addr = 0; inst_wdata = 0; data_wdata = 0; mem_rdata = 0;
    idle(); reset = 1;
    tick();
    test_reset();
    test_first_grant();
    test_lock();
    test_order();
    test_full();
    test_spurious();
    test_abandon();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
